// File: rtl/l2_pmem_responder.sv
// Line-granular physical memory model behind the L2 cache. Each request is
// latched in IDLE, held for LATENCY cycles in BUSY, and completed with a
// one-cycle pmem_resp pulse in RESP. Reads return registered data in the RESP
// cycle; writes commit at the clock edge that ends RESP.
module l2_pmem_responder #(
   parameter int unsigned LATENCY    = 8,
   parameter int unsigned DEPTH_BITS = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,
   output logic         pmem_error
);

   localparam int unsigned Lines = 1 << DEPTH_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   state_e                state_q;
   logic [7:0]            count_q;
   logic                  op_write_q;
   logic [DEPTH_BITS-1:0] index_q;
   logic [255:0]          wdata_q;

   // Not reset so contents survive reset; relies on the zero power-up state of
   // the target's storage elements.
   logic [255:0] mem [Lines];

   logic [DEPTH_BITS-1:0] req_index;
   logic                  unused_addr;

   // Offset bits and bits above the index are ignored, so upper lines alias.
   assign req_index   = pmem_address[DEPTH_BITS+4:5];
   assign unused_addr = ^pmem_address;

   // Request FSM with registered pmem_resp, pmem_rdata and sticky pmem_error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         count_q    <= 8'd0;
         op_write_q <= 1'b0;
         index_q    <= '0;
         wdata_q    <= '0;
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
         pmem_error <= 1'b0;
      end else begin
         pmem_resp <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pmem_read || pmem_write) begin
                  // Write takes priority when both are asserted.
                  op_write_q <= pmem_write;
                  index_q    <= req_index;
                  wdata_q    <= pmem_wdata;
                  count_q    <= 8'(LATENCY - 1);
                  state_q    <= StBusy;
                  if (pmem_read && pmem_write) begin
                     pmem_error <= 1'b1;
                  end
               end
            end
            StBusy: begin
               if (count_q == 8'd0) begin
                  state_q   <= StResp;
                  pmem_resp <= 1'b1;
                  if (!op_write_q) begin
                     pmem_rdata <= mem[index_q];
                  end
               end else begin
                  count_q <= count_q - 8'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Write commit at the edge ending RESP; reset drops state to IDLE first,
   // so a write in flight at reset never lands.
   always_ff @(posedge clk) begin
      if (state_q == StResp && op_write_q) begin
         mem[index_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Directed bench for l2_pmem_responder at default parameters.
module tb_l2_pmem_responder;

   localparam int unsigned LATENCY = 8;

   logic         clk;
   logic         reset;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic         pmem_error;

   int passed = 0;
   int total  = 0;

   l2_pmem_responder #(
      .LATENCY    (LATENCY),
      .DEPTH_BITS (11)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .pmem_error   (pmem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drives a request in the cycle after the next rising edge, so a call made
   // during RESP lands in the following IDLE cycle. Inputs are then scrambled
   // after 'hold' edges. Returns the number of edges after the acceptance edge
   // until pmem_resp is seen (-1 on timeout); returns inside the RESP cycle.
   task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [255:0] wd, input int hold, output int lat);
      @(posedge clk); #1;
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = addr;
      pmem_wdata   = wd;
      @(posedge clk); #1;
      if (hold == 0) begin
         pmem_read    = 1'b0;
         pmem_write   = 1'b0;
         pmem_address = ~addr;
         pmem_wdata   = ~wd;
      end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == hold) begin
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = ~addr;
            pmem_wdata   = ~wd;
         end
         if (pmem_resp) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      logic [255:0] aa;
      logic [255:0] fives;
      logic [255:0] pat;
      logic [255:0] beef;
      int lat;
      int extra;

      aa    = {32{8'hAA}};
      fives = {32{8'h55}};
      pat   = {16{16'h1234}};
      beef  = {8{32'hDEADBEEF}};

      reset        = 1'b1;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0000;
      pmem_wdata   = '0;

      #2;
      check("reset_resp", 256'(pmem_resp), 256'd0);
      check("reset_rdata", pmem_rdata, 256'd0);
      check("reset_error", 256'(pmem_error), 256'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Power-up read of line 0.
      req(1'b1, 1'b0, 16'h0000, '0, 0, lat);
      check("rd0_latency", 256'(lat), 256'(LATENCY));
      check("rd0_data", pmem_rdata, 256'd0);
      @(posedge clk); #1;
      check("rd0_pulse_width", 256'(pmem_resp), 256'd0);
      check("rd0_data_held", pmem_rdata, 256'd0);

      // Write then read of the same line through a different offset.
      req(1'b0, 1'b1, 16'h1240, aa, 0, lat);
      check("wr1240_latency", 256'(lat), 256'(LATENCY));
      check("wr1240_rdata_untouched", pmem_rdata, 256'd0);
      @(posedge clk); #1;
      check("wr1240_pulse_width", 256'(pmem_resp), 256'd0);
      check("wr1240_no_error", 256'(pmem_error), 256'd0);
      req(1'b1, 1'b0, 16'h125E, '0, 0, lat);
      check("rd125e_latency", 256'(lat), 256'(LATENCY));
      check("rd125e_data", pmem_rdata, aa);

      // Read held for two cycles after acceptance: one response only.
      req(1'b1, 1'b0, 16'h0040, '0, 2, lat);
      check("rd0040_latency", 256'(lat), 256'(LATENCY));
      check("rd0040_data", pmem_rdata, 256'd0);
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (pmem_resp) extra++;
      end
      check("rd0040_no_second_resp", 256'(extra), 256'd0);

      // Read and write together: write performed, sticky error raised.
      req(1'b1, 1'b1, 16'h0080, fives, 0, lat);
      check("both_latency", 256'(lat), 256'(LATENCY));
      check("both_error", 256'(pmem_error), 256'd1);
      check("both_rdata_untouched", pmem_rdata, 256'd0);
      req(1'b1, 1'b0, 16'h0080, '0, 0, lat);
      check("rd0080_data", pmem_rdata, fives);
      check("error_sticky", 256'(pmem_error), 256'd1);

      // Back-to-back write then read of the same line, no gap.
      req(1'b0, 1'b1, 16'h0100, beef, 0, lat);
      check("wr0100_latency", 256'(lat), 256'(LATENCY));
      check("wr0100_rdata_untouched", pmem_rdata, fives);
      req(1'b1, 1'b0, 16'h0100, '0, 0, lat);
      check("b2b_rd_latency", 256'(lat), 256'(LATENCY));
      check("b2b_rd_data", pmem_rdata, beef);

      // Reset in the middle of a write: outputs clear at once, write dropped.
      @(posedge clk); #1;
      pmem_write   = 1'b1;
      pmem_address = 16'h00A0;
      pmem_wdata   = pat;
      @(posedge clk); #1;
      pmem_write   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_busy_resp", 256'(pmem_resp), 256'd0);
      check("rst_busy_error", 256'(pmem_error), 256'd0);
      check("rst_busy_rdata", pmem_rdata, 256'd0);
      @(negedge clk);
      reset = 1'b0;
      req(1'b1, 1'b0, 16'h00A0, '0, 0, lat);
      check("rd00a0_latency", 256'(lat), 256'(LATENCY));
      check("rd00a0_discarded", pmem_rdata, 256'd0);
      check("rd00a0_error", 256'(pmem_error), 256'd0);

      // Contents survive reset.
      req(1'b1, 1'b0, 16'h1240, '0, 0, lat);
      check("rd1240_after_reset", pmem_rdata, aa);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/l2_pmem_responder.md
L2_PMEM_RESPONDER -- requirements
Module: l2_pmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 8, meaning cycles from request acceptance to pmem_resp (legal range 1..255).
REQ-002 The block SHALL have parameter DEPTH_BITS, default 11, meaning log2 of the number of 256-bit lines stored.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port pmem_read  input  1  line read request from the L2 cache.
REQ-006 The block SHALL have port pmem_write  input  1  line write request from the L2 cache.
REQ-007 The block SHALL have port pmem_address  input  16 (lc3b_word)  byte address; line address is bits [15:5].
REQ-008 The block SHALL have port pmem_wdata  input  256 (lc3b_d_line)  write line data.
REQ-009 The block SHALL have port pmem_rdata  output  256 (lc3b_d_line)  read line data.
REQ-010 The block SHALL have port pmem_resp  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port pmem_error  output  1  sticky protocol-error flag.

Function
REQ-012 Storage SHALL be 2^DEPTH_BITS lines of 256 bits, indexed by pmem_address[DEPTH_BITS+4:5]; address bits [4:0] ignored; bits above DEPTH_BITS+4 ignored (aliasing).
REQ-013 FSM states SHALL be IDLE, BUSY, RESP.
REQ-014 IDLE: when pmem_read or pmem_write is high, SHALL latch operation, line index and pmem_wdata, load counter with LATENCY-1, go to BUSY.
REQ-015 BUSY: counter SHALL decrement each cycle; at counter 0 go to RESP; BUSY lasts exactly LATENCY cycles.
REQ-016 RESP: pmem_resp SHALL be 1 for exactly that one cycle; next state IDLE.
REQ-017 Request sampled at cycle N SHALL yield pmem_resp at cycle N+LATENCY+1.
REQ-018 Read: pmem_rdata SHALL be registered and valid in the RESP cycle, holding that value until the next read's RESP or reset.
REQ-019 Write: the latched pmem_wdata SHALL be committed to the latched line at the clock edge ending the RESP cycle; pmem_rdata unchanged by writes.
REQ-020 Inputs SHALL be ignored in BUSY and RESP; latched values alone determine the operation (deasserting or changing a request mid-operation does not abort or alter it).
REQ-021 A new request SHALL be accepted in the IDLE cycle directly after RESP; no mandatory gap.
REQ-022 pmem_read and pmem_write both high in IDLE: SHALL perform the write only and set pmem_error.
REQ-023 pmem_error SHALL stay 1 until reset.
REQ-024 Read of a line written earlier SHALL return the most recent written data; write-then-read back-to-back to the same line SHALL return the new data.
REQ-025 Storage contents SHALL be zero at power-up.

Reset
REQ-026 Reset high SHALL immediately force state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, pmem_error 0.
REQ-027 Reset SHALL NOT alter storage contents; a write in flight at reset SHALL be discarded (not committed).
REQ-028 First request SHALL be sampled on the first rising edge with reset low.

Verification
REQ-029 Write 0xAAAA...AA to address 0x1240, LATENCY=8 -> pmem_resp high exactly 9 cycles after request edge, one cycle; then read 0x125E -> pmem_rdata = 0xAAAA...AA in RESP cycle.
REQ-030 Read 0x0000 after power-up -> pmem_rdata = 0 in RESP; pmem_resp pulse width 1; pmem_rdata held at 0 after.
REQ-031 Read 0x0040 with pmem_read dropped 2 cycles after acceptance -> pmem_resp still at cycle N+9; no second response.
REQ-032 Both pmem_read and pmem_write high with pmem_wdata=0x55...55 at 0x0080 -> pmem_error=1 and stays 1; later read 0x0080 returns 0x55...55.
REQ-033 Write 0x1234... to 0x00A0, reset asserted in BUSY -> pmem_resp/pmem_error/pmem_rdata 0 immediately; read 0x00A0 afterward returns previous contents (0).
REQ-034 Back-to-back write 0x0100 then read 0x0100 issued in the IDLE cycle after RESP -> second pmem_resp exactly LATENCY+1 cycles after second acceptance, data = written value.
